// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_arbiter
// Brief    : Round-robin arbiter with level requests and single-cycle grants.
//            A request is granted between 2 and N+1 edges after it is first
//            sampled. Also provides a sticky latency-violation flag and a
//            saturating grant counter.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en_i,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_vld_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
  output logic                 lat_err_o,
  output logic [CNT_W-1:0]     gnt_cnt_o
);

  localparam int ID_W = $clog2(N);
  localparam int W_W  = $clog2(N + 2);
  // Largest legal wait value; one more unserved enabled edge is a violation.
  localparam logic [W_W-1:0]  W_MAX    = W_W'(N + 1);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N - 1);

  logic [N-1:0]     pend_q;
  logic [N-1:0]     gnt_q;
  logic [N-1:0]     gnt_d;
  logic [N-1:0]     elig;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic [ID_W-1:0]  gnt_id_q;
  logic [ID_W-1:0]  gnt_id_d;
  logic [ID_W-1:0]  sel_idx;
  logic             found;
  int               cand;
  logic             lat_err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [N-1:0]     w_err;

  // A request is eligible once it has been seen for a full edge (pend_q), and
  // the master holding the current grant is excluded so grants always rotate.
  assign elig = req_i & pend_q & ~gnt_q;

  // Search for the first eligible master starting at the priority pointer.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && elig[ID_W'(cand)]) begin
        found   = 1'b1;
        sel_idx = ID_W'(cand);
      end
    end
  end

  // Next grant vector, grant index and pointer; nothing is selected while disabled.
  always_comb begin
    gnt_d    = '0;
    gnt_id_d = '0;
    ptr_d    = ptr_q;
    if (arb_en_i && found) begin
      gnt_d[sel_idx] = 1'b1;
      gnt_id_d       = sel_idx;
      ptr_d          = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
    end
  end

  // Saturating count of cycles with a grant pulse.
  always_comb begin
    cnt_d = cnt_q;
    if ((|gnt_q) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // One wait counter per master tracking how long its request has been unserved.
  generate
    for (genvar i = 0; i < N; i++) begin : g_wait
      logic [W_W-1:0] w_q;

      assign w_err[i] = arb_en_i & req_i[i] & ~gnt_q[i] & (w_q == W_MAX);

      // Clear on idle or on grant, hold while disabled, saturate at the limit.
      always_ff @(posedge clk) begin
        if (rst) begin
          w_q <= '0;
        end else if (!req_i[i]) begin
          w_q <= '0;
        end else if (arb_en_i) begin
          if (gnt_q[i]) begin
            w_q <= '0;
          end else if (w_q != W_MAX) begin
            w_q <= w_q + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      lat_err_q <= 1'b0;
    end else begin
      pend_q    <= req_i & ~gnt_q;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      lat_err_q <= lat_err_q | (|w_err);
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_vld_o = |gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign lat_err_o = lat_err_q;
  assign gnt_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_arbiter
// Brief    : Self-checking bench for rr_grant_arbiter (N=4): directed
//            scenarios plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

  localparam int N     = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             arb_en;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic             gnt_vld;
  logic [1:0]       gnt_id;
  logic             lat_err;
  logic [CNT_W-1:0] gnt_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state (plain integers and flags per master).
  int m_ptr;
  bit m_pend   [N];
  bit m_g      [N];
  bit m_sampled[N];
  int m_w      [N];
  bit m_err;
  int m_cnt;

  rr_grant_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_en_i  (arb_en),
    .req_i     (req),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id),
    .lat_err_o (lat_err),
    .gnt_cnt_o (gnt_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ptr = 0;
    m_err = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_g[i]    = 1'b0;
      m_w[i]    = 0;
    end
  endfunction

  // Apply one clock edge to the model using the inputs present at that edge.
  function automatic void model_step();
    int  sel;
    bit  any_g;
    int  i;
    for (int k = 0; k < N; k++) m_sampled[k] = m_g[k];
    if (rst) begin
      model_reset();
      return;
    end
    sel = -1;
    if (arb_en) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (sel < 0 && req[i] && m_pend[i] && !m_g[i]) sel = i;
      end
    end
    any_g = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (m_g[k]) any_g = 1'b1;
      if (!req[k]) m_w[k] = 0;
      else if (arb_en) begin
        if (m_g[k]) m_w[k] = 0;
        else if (m_w[k] == N + 1) m_err = 1'b1;
        else m_w[k] = m_w[k] + 1;
      end
    end
    if (any_g && m_cnt < 65535) m_cnt = m_cnt + 1;
    for (int k = 0; k < N; k++) begin
      m_pend[k] = req[k] && !m_g[k];
      m_g[k]    = (k == sel);
    end
    if (sel >= 0) m_ptr = (sel + 1) % N;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    arb_en = 1'b1;
    req    = '0;
    do_reset();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (gnt_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", gnt_vld); end
    checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", gnt_id); end
    checks++; if (lat_err !== 1'b0) begin failures++; $display("FAIL reset_lat_err got=%b exp=0", lat_err); end
    checks++; if (gnt_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", gnt_cnt); end
  endtask

  task automatic test_isolated();
    do_reset();
    req = 4'b0001;
    tick();  // first sample
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL iso_early got=%b exp=0000", gnt); end
    tick();  // selected
    checks++; if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_vld !== 1'b1) begin
      failures++; $display("FAIL iso_grant got=%b id=%0d vld=%b exp=0001 id=0 vld=1", gnt, gnt_id, gnt_vld); end
    tick();  // grant sampled
    req = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL iso_single_pulse got=%b exp=0000", gnt); end
    checks++; if (gnt_cnt !== 16'd1 || lat_err !== 1'b0) begin
      failures++; $display("FAIL iso_cnt got cnt=%0d err=%b exp cnt=1 err=0", gnt_cnt, lat_err); end
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL iso_no_regrant got=%b exp=0000", gnt); end
  endtask

  task automatic test_all_four();
    logic [N-1:0] exp;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < N; k++) begin
      tick();
      if (k > 0) req[k-1] = 1'b0;
      exp = 4'b0001 << k;
      checks++; if (gnt !== exp || gnt_id !== 2'(k)) begin
        failures++; $display("FAIL burst_grant%0d got=%b id=%0d exp=%b id=%0d", k, gnt, gnt_id, exp, k); end
    end
    tick();
    req[N-1] = 1'b0;
    checks++; if (gnt !== 4'b0000 || gnt_cnt !== 16'd4 || lat_err !== 1'b0) begin
      failures++; $display("FAIL burst_end got gnt=%b cnt=%0d err=%b exp gnt=0000 cnt=4 err=0", gnt, gnt_cnt, lat_err); end
  endtask

  task automatic test_pointer();
    do_reset();
    req = 4'b0010;
    tick(); tick(); tick();
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick();  // first sample
    tick();  // pointer is 2: search 2,3,0 -> master 0
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL ptr_first got=%b exp=0001", gnt); end
    tick();
    req[0] = 1'b0;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL ptr_second got=%b exp=0010", gnt); end
    tick();
    req[1] = 1'b0;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL ptr_done got=%b exp=0000", gnt); end
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    req = 4'b0000;  // withdrawn after selection
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL wd_pulse got=%b exp=0010", gnt); end
    tick();
    checks++; if (gnt !== 4'b0000 || gnt_cnt !== 16'd1) begin
      failures++; $display("FAIL wd_after got gnt=%b cnt=%0d exp gnt=0000 cnt=1", gnt, gnt_cnt); end
    tick(); tick();
    checks++; if (gnt !== 4'b0000 || lat_err !== 1'b0) begin
      failures++; $display("FAIL wd_no_second got gnt=%b err=%b exp gnt=0000 err=0", gnt, lat_err); end
  endtask

  task automatic test_disabled();
    int seen;
    do_reset();
    arb_en = 1'b0;
    req    = 4'b0100;
    seen   = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (gnt !== 4'b0000) seen++;
    end
    checks++; if (seen != 0 || lat_err !== 1'b0) begin
      failures++; $display("FAIL dis_hold got grants=%0d err=%b exp grants=0 err=0", seen, lat_err); end
    arb_en = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      failures++; $display("FAIL dis_reenable got=%b id=%0d exp=0100 id=2", gnt, gnt_id); end
    tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0000 || gnt_cnt !== 16'd1 || lat_err !== 1'b0) begin
      failures++; $display("FAIL dis_end got gnt=%b cnt=%0d err=%b exp 0000/1/0", gnt, gnt_cnt, lat_err); end
  endtask

  // Grant edges always fall on disabled edges, so the wait counter never clears
  // and keeps climbing across enabled edges.
  task automatic test_lat_err();
    do_reset();
    req = 4'b0100;
    for (int k = 0; k <= 8; k++) begin
      arb_en = (k % 2 == 0);
      tick();
    end
    checks++; if (lat_err !== 1'b0) begin failures++; $display("FAIL lat_after5 got=%b exp=0", lat_err); end
    arb_en = 1'b0; tick();
    arb_en = 1'b1; tick();
    checks++; if (lat_err !== 1'b1) begin failures++; $display("FAIL lat_after6 got=%b exp=1", lat_err); end
    req = 4'b0000;
    tick(); tick();
    checks++; if (lat_err !== 1'b1) begin failures++; $display("FAIL lat_sticky got=%b exp=1", lat_err); end
    arb_en = 1'b1;
  endtask

  task automatic test_rst_mid_burst();
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    tick();
    req[0] = 1'b0;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rstb_pre got=%b exp=0010", gnt); end
    rst = 1'b1;
    req = 4'b1111;
    tick();
    rst = 1'b0;
    checks++; if (gnt !== 4'b0000 || gnt_cnt !== 16'd0) begin
      failures++; $display("FAIL rstb_clear got gnt=%b cnt=%0d exp 0000/0", gnt, gnt_cnt); end
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rstb_first got=%b exp=0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rstb_restart got=%b exp=0001", gnt); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_g;
    int           exp_id;
    int           bad;
    bad = 0;
    do_reset();
    model_reset();
    req = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst    = ($urandom_range(0, 199) == 0);
      arb_en = ($urandom_range(0, 99) < 85);
      tick();
      exp_g  = '0;
      exp_id = 0;
      for (int i = 0; i < N; i++) if (m_g[i]) begin exp_g[i] = 1'b1; exp_id = i; end
      checks++;
      if (gnt !== exp_g || gnt_vld !== (|exp_g) || gnt_id !== 2'(exp_id) ||
          lat_err !== m_err || gnt_cnt !== 16'(m_cnt)) begin
        failures++;
        if (bad < 10)
          $display("FAIL rand_cyc%0d got gnt=%b id=%0d err=%b cnt=%0d exp gnt=%b id=%0d err=%b cnt=%0d",
                   cyc, gnt, gnt_id, lat_err, gnt_cnt, exp_g, exp_id, m_err, m_cnt);
        bad++;
      end
      for (int i = 0; i < N; i++) begin
        if (req[i] && m_sampled[i]) req[i] = ($urandom_range(0, 9) == 0);
        else if (req[i]) req[i] = ($urandom_range(0, 99) >= 4);
        else req[i] = ($urandom_range(0, 99) < 30);
      end
    end
    rst    = 1'b0;
    arb_en = 1'b1;
    req    = '0;
  endtask

  initial begin
    rst    = 1'b1;
    arb_en = 1'b1;
    req    = '0;
    model_reset();
    test_reset();
    test_isolated();
    test_all_four();
    test_pointer();
    test_withdraw();
    test_disabled();
    test_lat_err();
    test_rst_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter sharing one resource among N masters over a level request / single-cycle grant handshake. Every request is granted no earlier than 2 and no later than N+1 clock edges after it is first sampled. For N=4 this is the 2-to-5-cycle grant contract the bus checkers enforce. Sits between the master request lines and the shared slave port, with a sticky latency-violation flag and a grant counter for bench and debug use.

## Interface
- N, 4, number of requesters (2..16); guaranteed max grant latency is N+1 edges
- CNT_W, 16, width of the grant counter
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- arb_en  in  1  1 = arbitration enabled; 0 = no new grant selected
- req  in  N  per-master request, level, held until grant sampled
- gnt  out  N  one-hot grant pulse, or all zero
- gnt_vld  out  1  OR of gnt
- gnt_id  out  $clog2(N)  index of granted master; 0 when gnt_vld=0
- lat_err  out  1  sticky: some request waited more than N+1 edges
- gnt_cnt  out  CNT_W  total grants issued, saturating

## Operation
- Reset values: gnt=0, gnt_vld=0, gnt_id=0, lat_err=0, gnt_cnt=0, pend=0, all wait counters=0, rr pointer=0 (master 0 highest priority).
- pend[i] register: next = req[i] & ~gnt[i]. A request becomes eligible only one edge after it is first sampled. This produces the 2-edge minimum latency.
- eligible = req & pend & ~gnt. The master being granted this cycle cannot be picked again.
- Selection at each edge with arb_en=1: choose the first eligible master starting at the pointer, wrapping N-1 to 0. Register it into gnt, one-hot, for exactly one cycle.
- If nothing is eligible or arb_en=0, the next gnt is 0.
- Pointer update: when master i is selected, the pointer becomes (i+1) mod N.
- Requester rule: keep req[i] high up to and including the edge where gnt[i] is sampled high, then drop it.
  - If req[i] is still high on the following edge, that edge is the first sample of a new request.
- Withdrawal: if req[i] drops before grant, pend[i] clears.
  - If master i was already selected, gnt[i] still pulses for one cycle.
  - The master must ignore the pulse. It is counted and is not an error.
- Wait counter w[i], width $clog2(N+2), updated only on edges with arb_en=1 and req[i]=1:
  - if gnt[i]=1, clear to 0;
  - else if w[i]==N+1, set lat_err and hold;
  - else increment.
- When req[i]=0, w[i] is cleared. When arb_en=0, w[i] holds.
- gnt_cnt increments on every cycle with gnt_vld=1 and saturates at all ones.
- lat_err is cleared only by rst.

## Timing
- Isolated request first sampled at edge E: selected at E+1, gnt high in cycle E+1..E+2, sampled at E+2. Latency is exactly 2.
- All N requests first sampled at the same edge E: granted in pointer order at E+2, E+3, …, E+N+1. One grant per cycle, no bubbles.
- Back-to-back grants: gnt can move to a different master on consecutive cycles. The same master can never be granted on two consecutive cycles.
- A new request arriving mid-burst joins the rotation. Its worst case is N-1 grants ahead of it plus 2, i.e. N+1.
- arb_en falling: a grant already registered still completes. No selection happens at edges where arb_en=0. On re-enable, the first grant is visible one edge later.
- rst asserted mid-burst: the next edge clears all state. Requests still high are then treated as newly sampled on the first edge after rst drops, giving latency 2 from that edge.
- Outputs are registered; there is no combinational path from req to gnt.

## Test plan
- N=4, reset, req=0001 first sampled at edge 12 and held -> gnt=0001 sampled at edge 14 only; gnt_id=0, gnt_cnt=1, lat_err=0.
- req=1111 sampled at edge E, each bit dropped after its grant -> grants 0001,0010,0100,1000 at E+2..E+5; gnt_cnt=4; lat_err=0.
- Pointer at 2 (after granting master 1), req=0011 -> master 0 granted before master 1 is re-granted. No master is granted on two consecutive cycles.
- req[1] withdrawn one cycle after being selected -> gnt=0010 still pulses once; pend[1]=0 on the next edge; no second grant.
- req=0100 held with arb_en=0 for 8 edges, then arb_en=1 -> no grant while disabled, lat_err=0, grant 2 edges after re-enable.
  - Separately, force arb_en=0 after the request has waited 5 enabled edges -> lat_err=1 on the 6th enabled edge without grant.
- rst pulsed while req=1111 and gnt=0010 -> gnt=0 and gnt_cnt=0 at the next edge; grants restart from master 0, 2 edges after rst drops.
